// File: rtl/osc_freq_meter.sv
// Frequency meter for the gated ring oscillator: gates osc_en, counts synchronized osc_in rising edges over a window.
// Optional warm-up stage before counting is compiled in with FMETER_WARMUP_EN.
module osc_freq_meter #(
  parameter int CNT_W         = 16,
  parameter int WIN_W         = 16,
  parameter int WARMUP_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] window,
  input  logic             osc_in,
  output logic             osc_en,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             ovf,
  output logic [1:0]       fsm_state
);

  // Handshake: start is a level sampled every clk; it is accepted only in IDLE or DONE
  // and ignored while busy. valid stays high in DONE until the next accepted start.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

`ifdef FMETER_WARMUP_EN
  localparam logic [1:0] WARMUP = 2'd1;
  localparam int         WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  logic [WARM_W-1:0] warm_cnt;
  logic [WIN_W-1:0]  win_q;
`else
  // Warm-up length has no effect when the warm-up stage is compiled out.
  if (WARMUP_CYCLES < 0) begin : g_no_warmup
  end
`endif

  logic [1:0]       state;
  logic             s1, s2, s3;
  logic             rise;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  // Synchronizer runs in every state so s3 already tracks osc_in at MEASURE entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= osc_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      win_cnt <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
`ifdef FMETER_WARMUP_EN
      warm_cnt <= '0;
      win_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
`ifdef FMETER_WARMUP_EN
            win_q    <= window;
            warm_cnt <= WARM_W'(WARMUP_CYCLES - 1);
            state    <= WARMUP;
`else
            win_cnt <= window;
            state   <= (window == '0) ? DONE : MEASURE;
`endif
          end
        end
`ifdef FMETER_WARMUP_EN
        WARMUP: begin
          if (warm_cnt == '0) begin
            win_cnt <= win_q;
            state   <= (win_q == '0) ? DONE : MEASURE;
          end else begin
            warm_cnt <= warm_cnt - WARM_W'(1);
          end
        end
`endif
        MEASURE: begin
          if (rise) begin
            if (&count_q) ovf_q <= 1'b1;
            else          count_q <= count_q + CNT_W'(1);
          end
          // win_cnt holds the MEASURE cycles still to run, including this one.
          if (win_cnt == WIN_W'(1)) state <= DONE;
          else                      win_cnt <= win_cnt - WIN_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE) && (state != DONE);
  assign osc_en    = busy;
  assign valid     = (state == DONE);
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign fsm_state = state;

endmodule

// File: doc/osc_freq_meter.md
# osc_freq_meter

Digital frequency meter that sits directly downstream of the gated ring oscillator in the analog front-end top level. Drives the oscillator enable, counts rising edges of the returned oscillator output over a programmable window of system clocks, and presents a saturating count with a valid flag. Used for oscillator characterisation and on-chip trimming of the gated ring oscillator.

## Interface
- CNT_W, 16, width of edge counter / result
- WIN_W, 16, width of window length input
- WARMUP_CYCLES, 64, clk cycles oscillator runs before counting (only with warm-up compiled in)
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request a measurement; sampled each clk
- window  input  WIN_W  measurement length in clk cycles; captured on accepted start
- osc_in  input  1  oscillator output (osc_out of the front end), asynchronous to clk
- osc_en  output  1  oscillator enable (drives osc_en of the front end)
- busy  output  1  measurement in progress
- count  output  CNT_W  number of osc_in rising edges in the window
- valid  output  1  count holds a completed result
- ovf  output  1  count saturated during last measurement

## Operation
- osc_in passes through a 2-flop synchronizer (s1, s2) then a delay flop s3; rising edge = s2 & ~s3.
- FSM states: IDLE, WARMUP, MEASURE, DONE.
- IDLE: osc_en=0, busy=0. start=1 -> capture window into win_q, clear count/ovf/valid, go WARMUP (or MEASURE if warm-up compiled out).
- WARMUP: osc_en=1, busy=1; down-counter from WARMUP_CYCLES-1; at 0 -> MEASURE. No edges counted.
- MEASURE: osc_en=1, busy=1; window counter decrements each cycle; each detected edge increments count. Terminal: after exactly win_q cycles in MEASURE -> DONE. Edge detected on the final MEASURE cycle is counted.
- window=0: MEASURE skipped; go straight from WARMUP (or IDLE) to DONE with count=0.
- DONE: osc_en=0, busy=0, valid=1; count/ovf held. start=1 -> same as IDLE acceptance (valid drops next cycle). Without start, stays in DONE.
- start while busy is ignored; win_q unchanged.
- Saturation: count at all-ones stays all-ones on further edges; ovf set and held until next accepted start.
- Synchronizer/edge flops reset to 0 and keep running in all states, so an osc_in level high at MEASURE entry does not create a false edge unless s3 was low.
- Meaningful only for osc_in frequency < clk/2; higher frequencies alias (documented limitation, not detected).

## Timing
- Reset (rst_n=0 at clk edge): state=IDLE, osc_en=0, busy=0, count=0, valid=0, ovf=0, s1/s2/s3=0, internal counters 0. Reset mid-measurement aborts immediately, no result.
- Accepted start at edge N: busy=1 and osc_en=1 from N+1.
- Warm-up in: MEASURE entered at N+1+WARMUP_CYCLES; DONE (valid=1, busy=0, osc_en=0) at N+1+WARMUP_CYCLES+window.
- Warm-up out: DONE at N+1+window.
- osc_in transition to counted edge: 3 clk latency (2 sync + edge flop).

## Configuration
- FMETER_WARMUP_EN defined: WARMUP state and its counter built; oscillator runs WARMUP_CYCLES before counting to let it settle.
- Undefined: no WARMUP state/counter; accepted start goes directly to MEASURE; WARMUP_CYCLES parameter ignored.

## Test plan
- Reset: assert rst_n=0 two cycles with osc_in toggling -> osc_en=0, busy=0, valid=0, count=0, ovf=0.
- Basic: osc_in period 10 clk, window=100, start pulse -> valid=1 at documented cycle, count=10 (±1 for phase), ovf=0, osc_en high exactly during WARMUP+MEASURE.
- Zero window: window=0, start -> DONE with count=0, valid=1, no MEASURE cycles.
- Saturation: CNT_W=8, osc_in period 4 clk, window=2000 -> count=255, ovf=1; next start clears ovf/valid.
- Reset mid-measurement: rst_n=0 during MEASURE -> next cycle all outputs at reset values; subsequent start with window=50, period 10 -> count=5.
- Busy start ignored: start re-asserted with window=7 during MEASURE of window=100 -> measurement completes at original length, count reflects 100-cycle window.
